// File: rtl/mem_req_pkg.sv
// Shared types and default sizes for the main-memory request master.
//   state_t : controller states (IDLE, WAIT, RESP)
//   op_t    : latched operation kind (OP_LOAD, OP_STORE)
//   DEF_*   : default bus widths and memory depth used by the top module
package mem_req_pkg;

   localparam int DEF_ADDR_W    = 13;
   localparam int DEF_DATA_W    = 13;
   localparam int DEF_MEM_DEPTH = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_t;

endpackage

// File: rtl/mem_req_timer.sv
// Timeout counter for the memory wait phase.
//   clk, reset : clock, asynchronous active-low reset
//   clr_i      : force the count to zero (held while not waiting)
//   en_i       : count this edge (waiting and no Done seen)
//   tc_o       : terminal count, high on the CYCLES-th counted edge
module mem_req_timer #(
   parameter int unsigned CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // cnt_q counts completed idle edges, so the edge that sees CYCLES-1 is
   // the CYCLES-th one without Done.
   assign tc_o = en_i && (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/mem_request_master.sv
// Initiator side of the main-memory read/write/Done handshake.
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES edges without Done (otherwise WAIT waits indefinitely).
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake from the control unit
//   req_write/addr/wdata  : request payload (1 = store)
//   rsp_valid/rdata/error : one-cycle response strobe and its payload
//   busy                  : memory transaction outstanding
//   mem_address/dataIn    : address and write data to memory
//   mem_write/mem_read    : strobes to memory, held until Done
//   mem_dataOut/mem_done  : read data and completion flag from memory
module mem_request_master
   import mem_req_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_dataOut,
   input  logic              mem_done
);

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              out_of_range;
   logic              tmo;

   assign out_of_range = 32'(req_addr) >= MEM_DEPTH;

`ifdef MEM_TIMEOUT_EN
   mem_req_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (state_q != WAIT),
      .en_i  ((state_q == WAIT) && !mem_done),
      .tc_o  (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = req_write ? OP_STORE : OP_LOAD;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (out_of_range) begin
                  // Rejected locally: memory never sees a strobe.
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = WAIT;
                  wr_d    = req_write;
                  rd_d    = !req_write;
               end
            end
         end
         WAIT: begin
            // Done is checked first so it beats a coincident timeout.
            if (mem_done) begin
               state_d = RESP;
               wr_d    = 1'b0;
               rd_d    = 1'b0;
               err_d   = 1'b0;
               rdata_d = (op_q == OP_LOAD) ? mem_dataOut : '0;
            end else if (tmo) begin
               state_d = RESP;
               wr_d    = 1'b0;
               rd_d    = 1'b0;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q == WAIT);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_error   = err_q;
   assign mem_address = addr_q;
   assign mem_dataIn  = wdata_q;
   assign mem_write   = wr_q;
   assign mem_read    = rd_q;

endmodule
